// File: rtl/uart_tx.sv
// Serial UART transmitter: 5-8 data bits, optional even parity, 1 or 2 stop bits, nine baud rates.
// Frame begins the cycle after acceptance; tx_ready is high only in IDLE, so a new byte waits until the frame ends.
module uart_tx #(
    parameter int CLK_FREQ = 100_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       config_register_ready,
    input  logic [3:0] baud_rate,
    input  logic [1:0] data_size,
    input  logic       parity_bit,
    input  logic       stop_bits,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_serial,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam logic [15:0] DIV_0 = 16'(CLK_FREQ / 9600);
    localparam logic [15:0] DIV_1 = 16'(CLK_FREQ / 19200);
    localparam logic [15:0] DIV_2 = 16'(CLK_FREQ / 38400);
    localparam logic [15:0] DIV_3 = 16'(CLK_FREQ / 57600);
    localparam logic [15:0] DIV_4 = 16'(CLK_FREQ / 115200);
    localparam logic [15:0] DIV_5 = 16'(CLK_FREQ / 230400);
    localparam logic [15:0] DIV_6 = 16'(CLK_FREQ / 460800);
    localparam logic [15:0] DIV_7 = 16'(CLK_FREQ / 921600);
    localparam logic [15:0] DIV_8 = 16'(CLK_FREQ / 1843200);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t      state, state_n;
    logic [15:0] cnt, cnt_n;
    logic [15:0] div_q, div_sel;
    logic [2:0]  bit_idx, bit_idx_n;
    logic [7:0]  data_q;
    logic [1:0]  size_q;
    logic        par_q;
    logic        stop_q;
    logic        accept;
    logic        bit_end;

    always_comb begin
        case (baud_rate)
            4'd1:    div_sel = DIV_1;
            4'd2:    div_sel = DIV_2;
            4'd3:    div_sel = DIV_3;
            4'd4:    div_sel = DIV_4;
            4'd5:    div_sel = DIV_5;
            4'd6:    div_sel = DIV_6;
            4'd7:    div_sel = DIV_7;
            4'd8:    div_sel = DIV_8;
            default: div_sel = DIV_0;
        endcase
    end

    // Gating with rst keeps a same-cycle reset ahead of any acceptance.
    assign tx_ready = (state == IDLE) && config_register_ready && !rst;
    assign accept   = tx_ready && tx_valid;
    assign bit_end  = (cnt == div_q - 16'd1);
    assign tx_busy  = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            div_q   <= '0;
            data_q  <= '0;
            size_q  <= '0;
            par_q   <= 1'b0;
            stop_q  <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_idx_n;
            if (accept) begin
                // Unused upper bits are cleared so parity is a plain XOR of data_q.
                data_q <= tx_data & (8'hFF >> (2'd3 - data_size));
                div_q  <= div_sel;
                size_q <= data_size;
                par_q  <= parity_bit;
                stop_q <= stop_bits;
            end
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_idx_n = bit_idx;
        tx_serial = 1'b1;
        tx_done   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_n   = START;
                    cnt_n     = '0;
                    bit_idx_n = '0;
                end
            end
            START: begin
                tx_serial = 1'b0;
                if (bit_end) begin
                    cnt_n   = '0;
                    state_n = DATA;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            DATA: begin
                tx_serial = data_q[bit_idx];
                if (bit_end) begin
                    cnt_n = '0;
                    // Last data bit index is N-1 = 4 + data_size.
                    if (bit_idx == {1'b1, size_q}) begin
                        bit_idx_n = '0;
                        state_n   = par_q ? PARITY : STOP;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            PARITY: begin
                tx_serial = ^data_q;
                if (bit_end) begin
                    cnt_n   = '0;
                    state_n = STOP;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            STOP: begin
                tx_serial = 1'b1;
                if (bit_end) begin
                    cnt_n = '0;
                    if (bit_idx == {2'b00, stop_q}) begin
                        tx_done   = 1'b1;
                        bit_idx_n = '0;
                        state_n   = IDLE;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// Randomized bench for uart_tx: each frame's line waveform is predicted from a bit list and compared cycle by cycle.
module tb_uart_tx;
    localparam int CLK_FREQ = 100_000_000;

    logic       clk = 1'b0;
    logic       rst;
    logic       config_register_ready;
    logic [3:0] baud_rate;
    logic [1:0] data_size;
    logic       parity_bit;
    logic       stop_bits;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_serial;
    logic       tx_busy;
    logic       tx_done;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    uart_tx #(.CLK_FREQ(CLK_FREQ)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .config_register_ready (config_register_ready),
        .baud_rate             (baud_rate),
        .data_size             (data_size),
        .parity_bit            (parity_bit),
        .stop_bits             (stop_bits),
        .tx_data               (tx_data),
        .tx_valid              (tx_valid),
        .tx_ready              (tx_ready),
        .tx_serial             (tx_serial),
        .tx_busy               (tx_busy),
        .tx_done               (tx_done)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int div_of(input int code);
        int baud_tab [9] = '{9600, 19200, 38400, 57600, 115200, 230400, 460800, 921600, 1843200};
        return CLK_FREQ / baud_tab[(code > 8) ? 0 : code];
    endfunction

    // Present a byte and return just after the accepting rising edge.
    task automatic offer(input logic [7:0] d, input int code, input logic [1:0] sz,
                         input logic p, input logic s, input bit hold);
        int w;
        @(negedge clk);
        config_register_ready = 1'b1;
        tx_data    = d;
        baud_rate  = 4'(code);
        data_size  = sz;
        parity_bit = p;
        stop_bits  = s;
        tx_valid   = 1'b1;
        w = 0;
        while (tx_ready !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("ready_wait", tx_ready, 1);
        @(posedge clk);
        #1;
        if (!hold) tx_valid = 1'b0;
    endtask

    // Watch one frame starting the cycle after acceptance, against a bit-list model.
    task automatic observe(input logic [7:0] d, input int code, input logic [1:0] sz,
                           input logic p, input logic s, input bit scramble,
                           input string tag, output int done_at);
        int   div, n, nb, len, mism, dcnt, blow;
        logic bits [12];
        logic par;
        div = div_of(code);
        n   = 5 + int'(sz);
        par = 1'b0;
        bits[0] = 1'b0;
        for (int i = 0; i < n; i++) begin
            bits[1 + i] = d[i];
            par ^= d[i];
        end
        nb = 1 + n;
        if (p) begin
            bits[nb] = par;
            nb++;
        end
        bits[nb] = 1'b1;
        nb++;
        if (s) begin
            bits[nb] = 1'b1;
            nb++;
        end
        len = div * nb;
        mism = 0; dcnt = 0; blow = 0; done_at = -1;
        for (int k = 1; k <= len; k++) begin
            @(negedge clk);
            if (tx_serial !== bits[(k - 1) / div]) mism++;
            if (tx_done === 1'b1) begin
                dcnt++;
                if (done_at < 0) done_at = k;
            end
            if (tx_busy !== 1'b1) blow++;
            if (scramble) begin
                if (k < len) begin
                    tx_data               = 8'($urandom);
                    baud_rate             = 4'($urandom);
                    data_size             = 2'($urandom);
                    parity_bit            = 1'($urandom);
                    stop_bits             = 1'($urandom);
                    config_register_ready = 1'($urandom);
                    tx_valid              = 1'($urandom);
                end else begin
                    tx_valid              = 1'b0;
                    config_register_ready = 1'b1;
                end
            end
        end
        check({tag, "_line_errs"}, mism, 0);
        check({tag, "_done_at"}, done_at, len);
        check({tag, "_done_pulses"}, dcnt, 1);
        check({tag, "_busy_low"}, blow, 0);
        if (scramble) begin
            @(negedge clk);
            check({tag, "_idle_after"}, tx_busy, 0);
        end
    endtask

    initial begin
        int da, cnt_r, cnt_l, cnt_b, lows;
        logic [7:0] d;
        int code;
        logic [1:0] sz;
        logic p, s;

        rst = 1'b1;
        config_register_ready = 1'b1;
        baud_rate = 4'd8; data_size = 2'd3; parity_bit = 1'b0; stop_bits = 1'b0;
        tx_data = 8'h3C; tx_valid = 1'b1;

        // Reset state, with a pending offer that must not be taken
        @(negedge clk);
        check("rst_ready", tx_ready, 0);
        check("rst_serial", tx_serial, 1);
        check("rst_busy", tx_busy, 0);
        check("rst_done", tx_done, 0);
        @(negedge clk);
        check("rst_no_accept", tx_busy, 0);
        tx_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("idle_ready", tx_ready, 1);

        // 8N1 0xA5 at 1843200 baud
        offer(8'hA5, 8, 2'd3, 1'b0, 1'b0, 0);
        observe(8'hA5, 8, 2'd3, 1'b0, 1'b0, 0, "a5", da);
        check("a5_done_cycle", da, 540);

        // 7E2 0xFF: bit 7 dropped, parity over seven ones is 1
        offer(8'hFF, 8, 2'd2, 1'b1, 1'b1, 0);
        observe(8'hFF, 8, 2'd2, 1'b1, 1'b1, 0, "ff7e2", da);
        check("ff7e2_done_cycle", da, 594);

        // Config not ready: offers are refused
        @(negedge clk);
        config_register_ready = 1'b0;
        tx_valid = 1'b1;
        cnt_r = 0; cnt_l = 0; cnt_b = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (tx_ready !== 1'b0) cnt_r++;
            if (tx_serial !== 1'b1) cnt_l++;
            if (tx_busy !== 1'b0) cnt_b++;
        end
        check("nocfg_ready", cnt_r, 0);
        check("nocfg_line", cnt_l, 0);
        check("nocfg_busy", cnt_b, 0);
        tx_valid = 1'b0;
        config_register_ready = 1'b1;

        // Back-to-back 0x00 then 0xFF with tx_valid held
        offer(8'h00, 8, 2'd3, 1'b0, 1'b0, 1);
        tx_data = 8'hFF;
        observe(8'h00, 8, 2'd3, 1'b0, 1'b0, 0, "b2b0", da);
        @(negedge clk);
        check("b2b_ready", tx_ready, 1);
        check("b2b_gap_line", tx_serial, 1);
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        observe(8'hFF, 8, 2'd3, 1'b0, 1'b0, 0, "b2b1", da);

        // Reset at cycle 100 of a 0x55 frame
        offer(8'h55, 8, 2'd3, 1'b0, 1'b0, 0);
        for (int k = 1; k <= 100; k++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_serial", tx_serial, 1);
        check("abort_busy", tx_busy, 0);
        cnt_r = 0; cnt_b = 0;
        for (int k = 0; k < 600; k++) begin
            if (tx_done !== 1'b0) cnt_r++;
            if (tx_busy !== 1'b0) cnt_b++;
            @(negedge clk);
        end
        check("abort_no_done", cnt_r, 0);
        check("abort_stays_idle", cnt_b, 0);

        // Code 15 falls back to 9600 baud: measure the start bit, then abort
        offer(8'h81, 15, 2'd3, 1'b0, 1'b0, 0);
        lows = 0;
        @(negedge clk);
        while (tx_serial === 1'b0 && lows < 11000) begin
            lows++;
            @(negedge clk);
        end
        check("code15_start_len", lows, div_of(15));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("code15_abort_busy", tx_busy, 0);

        // Random frames with every input scrambled while the frame runs
        for (int f = 0; f < 12; f++) begin
            d    = 8'($urandom);
            code = $urandom_range(6, 8);
            sz   = 2'($urandom);
            p    = 1'($urandom);
            s    = 1'($urandom);
            offer(d, code, sz, p, s, 0);
            observe(d, code, sz, p, s, 1, $sformatf("rnd%0d", f), da);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
